// File: rtl/platform_collapse_ctl_if.sv
// Control bundle between the game logic and the platform collapse sequencer.
interface platform_collapse_ctl_if;
  logic       start_game;
  logic       vsync;
  logic       restore_all;
  logic [3:0] ctl;
  logic [1:0] step;
  logic       warn;
  logic       cycle_done;

  modport master (
    output start_game, vsync, restore_all,
    input  ctl, step, warn, cycle_done
  );

  modport slave (
    input  start_game, vsync, restore_all,
    output ctl, step, warn, cycle_done
  );
endinterface

// File: rtl/platform_collapse_ctl.sv
// Frame-timed sequencer that hides platform segments 0..3 in turn (blinking first),
// holds them all hidden, then restores and repeats while the game runs.
module platform_collapse_ctl #(
  parameter int FRAMES_PER_STEP = 300,
  parameter int WARN_FRAMES     = 120,
  parameter int BLINK_FRAMES    = 15,
  parameter int HOLD_FRAMES     = 180
) (
  input  logic                    clk,
  input  logic                    rst,
  platform_collapse_ctl_if.slave  bus
);

  localparam int MAX_AB = (FRAMES_PER_STEP > WARN_FRAMES) ? FRAMES_PER_STEP : WARN_FRAMES;
  localparam int MAX_CD = (BLINK_FRAMES > HOLD_FRAMES) ? BLINK_FRAMES : HOLD_FRAMES;
  localparam int MAX_P  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int W      = $clog2(MAX_P) + 1;

  localparam logic [W-1:0] WAIT_LAST  = W'(FRAMES_PER_STEP - WARN_FRAMES - 1);
  localparam logic [W-1:0] WARN_LEN   = W'(WARN_FRAMES);
  localparam logic [W-1:0] BLINK_LEN  = W'(BLINK_FRAMES);
  localparam logic [W-1:0] HOLD_LEN   = W'(HOLD_FRAMES);
  localparam logic [W-1:0] ONE        = W'(1);

  typedef enum logic [1:0] {IDLE, WAIT, WARN, HOLD} state_t;

  state_t       state_reg, state_next;
  logic [3:0]   ctl_reg, ctl_next;
  logic [1:0]   step_reg, step_next;
  logic         warn_reg, warn_next;
  logic         done_reg, done_next;
  logic [W-1:0] frame_reg, frame_next;
  logic [W-1:0] blink_reg, blink_next;
  logic         vsync_q_reg;
  logic         tick;
  logic         complete;

  assign tick = bus.vsync & ~vsync_q_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      ctl_reg     <= '0;
      step_reg    <= '0;
      warn_reg    <= 1'b0;
      done_reg    <= 1'b0;
      frame_reg   <= '0;
      blink_reg   <= '0;
      vsync_q_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      ctl_reg     <= ctl_next;
      step_reg    <= step_next;
      warn_reg    <= warn_next;
      done_reg    <= done_next;
      frame_reg   <= frame_next;
      blink_reg   <= blink_next;
      vsync_q_reg <= bus.vsync;
    end
  end

  always_comb begin
    state_next = state_reg;
    ctl_next   = ctl_reg;
    step_next  = step_reg;
    warn_next  = warn_reg;
    done_next  = 1'b0;
    frame_next = frame_reg;
    blink_next = blink_reg;
    complete   = 1'b0;

    if (!bus.start_game) begin
      state_next = IDLE;
      ctl_next   = '0;
      step_next  = '0;
      warn_next  = 1'b0;
      frame_next = '0;
      blink_next = '0;
    end else if (state_reg == IDLE) begin
      // Any tick coinciding with the start is dropped; counting begins in WAIT.
      state_next = WAIT;
      frame_next = '0;
    end else if (bus.restore_all) begin
      state_next = WAIT;
      ctl_next   = '0;
      step_next  = '0;
      warn_next  = 1'b0;
      frame_next = '0;
      blink_next = '0;
    end else if (tick) begin
      case (state_reg)
        WAIT: begin
          if (frame_reg == WAIT_LAST) begin
            if (WARN_FRAMES > 0) begin
              state_next          = WARN;
              ctl_next[step_reg]  = 1'b1;
              warn_next           = 1'b1;
              frame_next          = '0;
              blink_next          = '0;
            end else begin
              complete = 1'b1;
            end
          end else begin
            frame_next = frame_reg + ONE;
          end
        end
        WARN: begin
          // The final warning tick wins over a coincident blink toggle.
          if (frame_reg + ONE == WARN_LEN) begin
            complete = 1'b1;
          end else begin
            frame_next = frame_reg + ONE;
            if (blink_reg + ONE == BLINK_LEN) begin
              ctl_next[step_reg] = ~ctl_reg[step_reg];
              blink_next         = '0;
            end else begin
              blink_next = blink_reg + ONE;
            end
          end
        end
        HOLD: begin
          if (frame_reg + ONE == HOLD_LEN) begin
            state_next = WAIT;
            ctl_next   = '0;
            step_next  = '0;
            done_next  = 1'b1;
            frame_next = '0;
          end else begin
            frame_next = frame_reg + ONE;
          end
        end
        default: state_next = IDLE;
      endcase

      if (complete) begin
        ctl_next[step_reg] = 1'b1;
        warn_next          = 1'b0;
        frame_next         = '0;
        blink_next         = '0;
        if (step_reg == 2'd3) begin
          state_next = HOLD;
        end else begin
          step_next  = step_reg + 2'd1;
          state_next = WAIT;
        end
      end
    end
  end

  assign bus.ctl        = ctl_reg;
  assign bus.step       = step_reg;
  assign bus.warn       = warn_reg;
  assign bus.cycle_done = done_reg;

endmodule
